fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter and drives the synchronous instruction memory read port. It has a 1-cycle read latency, and its read data holds while read enable is low. The block issues sequential fetches, applies backpressure from decode by gating the memory read enable, and handles redirects (branch/jump) from execute. It also halts on a misaligned redirect target.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rstN  input  1  synchronous reset, active-low.
fetchEn  input  1  run enable from core control.
redirValid  input  1  redirect request (single-cycle pulse, level honoured).
redirPc  input  32  redirect target address.
memREn  output  1  imem read enable.
memOEn  output  1  imem output enable.
memAddr  output  32  imem byte address (word-aligned).
memRData  input  32  imem read data; valid the cycle after memREn.
instValid  output  1  instruction presented to decode.
instReady  input  1  decode accepts the instruction.
inst  output  32  instruction; combinational pass-through of memRData.
instPc  output  32  byte address of inst.
fetchErr  output  1  sticky misaligned-redirect flag.

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-low, `rstN`.
- States: IDLE, RUN, HALT.
- Reset (rstN=0 at an edge) gives the following values, regardless of the operation in progress:
  - state=IDLE, pc=RESET_PC, instValid=0, instPc=0, fetchErr=0.
  - memREn=0, memOEn=0.
- memOEn is always equal to memREn.
- memAddr mux:
  - redirPc when state=RUN and redirValid=1.
  - pc otherwise.
- Issue condition: state=RUN && fetchEn && (redirValid || !instValid || instReady).
  - memREn = issue.
- On issue at cycle t with address A:
  - pc<=A+4 (modulo 2^32; no range check, imem aliases).
  - At t+1: instValid=1, instPc=A, inst=mem[A].
  - Steady-state throughput is 1 instruction per cycle.
- Stall: instValid=1 && instReady=0 && no redirect.
  - memREn=0, so imem holds memRData.
  - inst, instPc and instValid are held unchanged.
- Accept without issue (instValid && instReady, issue=0): instValid<=0 next cycle.
- Redirect in RUN with redirPc[1:0]==0:
  - The currently presented instruction is squashed. Decode must ignore the handshake in that cycle.
  - A fetch of redirPc is issued the same cycle; pc<=redirPc+4.
  - Next cycle: instValid=1, instPc=redirPc. A stall does not block a redirect.
- Redirect in RUN with redirPc[1:0]!=0:
  - No issue; instValid<=0; fetchErr<=1; state->HALT.
- HALT: memREn=0, instValid=0, fetchErr=1. The block leaves HALT only by reset; inputs are ignored.
- IDLE:
  - memREn=0.
  - A held instValid remains until accepted, then clears.
  - fetchEn=1 -> RUN; the first issue occurs in the RUN cycle, not the IDLE cycle.
- fetchEn=0 while in RUN:
  - No issue that cycle; state->IDLE; pc is preserved, so fetching resumes at pc.
  - A held instruction stays valid until accepted.
- fetchEn=0 and an aligned redirValid in the same cycle:
  - pc<=redirPc, no issue, instValid<=0, state->IDLE.
  - Resume fetches redirPc.
- redirValid in IDLE or HALT is ignored.

Test Plan:
1. Reset with RESET_PC=0x100, then fetchEn=1, instReady=1 constant -> memAddr 0x100, 0x104, 0x108 on consecutive cycles. instPc follows one cycle later with instValid=1 continuously.
2. Hold instReady=0 for 3 cycles while instValid=1, instPc=0x104 -> memREn=0, inst/instPc stable for 3 cycles. Releasing gives issue of 0x108 and no lost or duplicated PC.
3. redirValid=1, redirPc=0x200 during a stall at instPc=0x104 -> memAddr=0x200 with memREn=1 that cycle. Next cycle instPc=0x200, then 0x204; 0x108 is never presented.
4. redirPc=0x202 -> memREn=0 thereafter, instValid=0, fetchErr=1 sticky. Only rstN=0 clears it; after reset pc=RESET_PC.
5. Drop fetchEn at pc=0x10C for 4 cycles -> no memREn, state IDLE. Re-assert -> first fetch at 0x10C.
6. Assert rstN=0 mid-stream with instValid=1 -> next edge instValid=0, memREn=0, instPc=0, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives a 1-cycle-latency imem read port,
// applies decode backpressure by gating read enable, and handles execute redirects.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        fetchEn,
    input  logic        redirValid,
    input  logic [31:0] redirPc,
    output logic        memREn,
    output logic        memOEn,
    output logic [31:0] memAddr,
    input  logic [31:0] memRData,
    output logic        instValid,
    input  logic        instReady,
    output logic [31:0] inst,
    output logic [31:0] instPc,
    output logic        fetchErr
);

    // state | meaning
    // IDLE  | not fetching; a held instruction drains on accept
    // RUN   | issuing fetches, honouring stalls and redirects
    // HALT  | misaligned redirect seen; frozen until reset
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] inst_pc_q, inst_pc_nxt;
    logic        inst_valid_q, inst_valid_nxt;
    logic        fetch_err_q, fetch_err_nxt;
    logic        redir_run, redir_bad, issue;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            inst_pc_q    <= 32'h0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            inst_pc_q    <= inst_pc_nxt;
            inst_valid_q <= inst_valid_nxt;
            fetch_err_q  <= fetch_err_nxt;
        end
    end

    always_comb begin
        redir_run      = (state == RUN) && redirValid;
        redir_bad      = redir_run && (redirPc[1:0] != 2'b00);
        memAddr        = redir_run ? redirPc : pc;
        // A redirect overrides a stall; a misaligned one never issues.
        issue          = (state == RUN) && fetchEn && !redir_bad &&
                         (redirValid || !inst_valid_q || instReady);
        state_nxt      = state;
        pc_nxt         = pc;
        inst_pc_nxt    = inst_pc_q;
        inst_valid_nxt = inst_valid_q;
        fetch_err_nxt  = fetch_err_q;
        case (state)
            IDLE: begin
                if (inst_valid_q && instReady)
                    inst_valid_nxt = 1'b0;
                if (fetchEn)
                    state_nxt = RUN;
            end
            RUN: begin
                if (redir_bad) begin
                    inst_valid_nxt = 1'b0;
                    fetch_err_nxt  = 1'b1;
                    state_nxt      = HALT;
                end else if (!fetchEn) begin
                    state_nxt = IDLE;
                    if (redirValid) begin
                        pc_nxt         = redirPc;
                        inst_valid_nxt = 1'b0;
                    end else if (inst_valid_q && instReady) begin
                        inst_valid_nxt = 1'b0;
                    end
                end else if (issue) begin
                    pc_nxt         = memAddr + 32'd4;
                    inst_pc_nxt    = memAddr;
                    inst_valid_nxt = 1'b1;
                end
            end
            HALT: begin
                inst_valid_nxt = 1'b0;
                fetch_err_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign memREn    = issue;
    assign memOEn    = issue;
    assign instValid = inst_valid_q;
    assign inst      = memRData;
    assign instPc    = inst_pc_q;
    assign fetchErr  = fetch_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural 1-cycle-latency imem.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rstN, fetchEn, redirValid, instReady;
    logic [31:0] redirPc;
    logic        memREn, memOEn, instValid, fetchErr;
    logic [31:0] memAddr, inst, instPc;
    logic [31:0] memRData = 32'h0;
    int          total = 0;
    int          bad = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rstN(rstN), .fetchEn(fetchEn), .redirValid(redirValid),
        .redirPc(redirPc), .memREn(memREn), .memOEn(memOEn), .memAddr(memAddr),
        .memRData(memRData), .instValid(instValid), .instReady(instReady),
        .inst(inst), .instPc(instPc), .fetchErr(fetchErr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    always @(posedge clk)
        if (memREn) memRData <= mem_word(memAddr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rstN = 1'b0; fetchEn = 1'b0; redirValid = 1'b0; redirPc = 32'h0; instReady = 1'b1;
        tick();
        tick();
        rstN = 1'b1;
        settle();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (instValid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instValid); end
        total++; if (instPc !== 32'h0) begin bad++; $display("FAIL rst_instpc got=%h exp=0", instPc); end
        total++; if (fetchErr !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", fetchErr); end
        total++; if (memREn !== 1'b0 || memOEn !== 1'b0) begin bad++; $display("FAIL rst_ren got=%b%b exp=00", memREn, memOEn); end
        total++; if (memAddr !== 32'h100) begin bad++; $display("FAIL rst_addr got=%h exp=100", memAddr); end
    endtask

    task automatic test_sequential();
        do_reset();
        fetchEn = 1'b1;
        settle();
        total++; if (memREn !== 1'b0) begin bad++; $display("FAIL idle_no_issue got=%b exp=0", memREn); end
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (memREn !== 1'b1 || memOEn !== 1'b1 || memAddr !== 32'h100 + 32'(4 * i)) begin
                bad++; $display("FAIL seq_addr%0d got=%b/%h exp=1/%h", i, memREn, memAddr, 32'h100 + 32'(4 * i));
            end
            if (i > 0) begin
                total++;
                if (instValid !== 1'b1 || instPc !== 32'h100 + 32'(4 * (i - 1)) ||
                    inst !== mem_word(32'h100 + 32'(4 * (i - 1)))) begin
                    bad++; $display("FAIL seq_inst%0d got=%b/%h/%h", i, instValid, instPc, inst);
                end
            end
            tick();
        end
    endtask

    task automatic run_to_104();
        do_reset();
        fetchEn = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic test_stall();
        run_to_104();
        instReady = 1'b0;
        settle();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (memREn !== 1'b0 || instValid !== 1'b1 || instPc !== 32'h104 || inst !== mem_word(32'h104)) begin
                bad++; $display("FAIL stall%0d ren=%b v=%b pc=%h inst=%h", i, memREn, instValid, instPc, inst);
            end
            tick();
        end
        instReady = 1'b1;
        settle();
        total++; if (memREn !== 1'b1 || memAddr !== 32'h108) begin bad++; $display("FAIL stall_release got=%b/%h exp=1/108", memREn, memAddr); end
        tick();
        total++; if (instPc !== 32'h108 || inst !== mem_word(32'h108)) begin bad++; $display("FAIL stall_next got=%h exp=108", instPc); end
    endtask

    task automatic test_redirect();
        run_to_104();
        instReady = 1'b0; redirValid = 1'b1; redirPc = 32'h200;
        settle();
        total++; if (memREn !== 1'b1 || memAddr !== 32'h200) begin bad++; $display("FAIL redir_issue got=%b/%h exp=1/200", memREn, memAddr); end
        tick();
        redirValid = 1'b0; instReady = 1'b1;
        settle();
        total++; if (instValid !== 1'b1 || instPc !== 32'h200 || inst !== mem_word(32'h200)) begin bad++; $display("FAIL redir_inst got=%b/%h exp=1/200", instValid, instPc); end
        total++; if (memAddr !== 32'h204) begin bad++; $display("FAIL redir_next_addr got=%h exp=204", memAddr); end
        tick();
        total++; if (instPc !== 32'h204) begin bad++; $display("FAIL redir_follow got=%h exp=204", instPc); end
    endtask

    task automatic test_misaligned();
        run_to_104();
        redirValid = 1'b1; redirPc = 32'h202;
        settle();
        total++; if (memREn !== 1'b0) begin bad++; $display("FAIL mis_no_issue got=%b exp=0", memREn); end
        tick();
        redirPc = 32'h300;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++;
            if (memREn !== 1'b0 || instValid !== 1'b0 || fetchErr !== 1'b1) begin
                bad++; $display("FAIL halt%0d ren=%b v=%b err=%b exp=0/0/1", i, memREn, instValid, fetchErr);
            end
            tick();
        end
        do_reset();
        total++; if (fetchErr !== 1'b0 || memAddr !== 32'h100) begin bad++; $display("FAIL halt_reset err=%b addr=%h exp=0/100", fetchErr, memAddr); end
    endtask

    task automatic test_pause();
        run_to_104();
        tick();
        fetchEn = 1'b0;
        settle();
        total++; if (memREn !== 1'b0 || memAddr !== 32'h10C) begin bad++; $display("FAIL pause_drop got=%b/%h exp=0/10c", memREn, memAddr); end
        tick();
        total++; if (instValid !== 1'b0) begin bad++; $display("FAIL pause_drain got=%b exp=0", instValid); end
        for (int i = 0; i < 3; i++) begin
            total++; if (memREn !== 1'b0) begin bad++; $display("FAIL pause_idle%0d got=%b exp=0", i, memREn); end
            tick();
        end
        fetchEn = 1'b1;
        settle();
        total++; if (memREn !== 1'b0) begin bad++; $display("FAIL resume_idle got=%b exp=0", memREn); end
        tick();
        total++; if (memREn !== 1'b1 || memAddr !== 32'h10C) begin bad++; $display("FAIL resume_addr got=%b/%h exp=1/10c", memREn, memAddr); end
        tick();
        total++; if (instValid !== 1'b1 || instPc !== 32'h10C) begin bad++; $display("FAIL resume_inst got=%b/%h exp=1/10c", instValid, instPc); end
    endtask

    task automatic test_redir_idle();
        run_to_104();
        fetchEn = 1'b0; redirValid = 1'b1; redirPc = 32'h400;
        settle();
        total++; if (memREn !== 1'b0) begin bad++; $display("FAIL ridle_issue got=%b exp=0", memREn); end
        tick();
        redirValid = 1'b0;
        settle();
        total++; if (instValid !== 1'b0 || memAddr !== 32'h400) begin bad++; $display("FAIL ridle_state v=%b addr=%h exp=0/400", instValid, memAddr); end
        fetchEn = 1'b1;
        tick();
        total++; if (memREn !== 1'b1 || memAddr !== 32'h400) begin bad++; $display("FAIL ridle_resume got=%b/%h exp=1/400", memREn, memAddr); end
    endtask

    task automatic test_mid_reset();
        run_to_104();
        rstN = 1'b0;
        settle();
        total++; if (instValid !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b exp=1", instValid); end
        tick();
        total++;
        if (instValid !== 1'b0 || memREn !== 1'b0 || instPc !== 32'h0 || memAddr !== 32'h100) begin
            bad++; $display("FAIL mid_reset v=%b ren=%b ipc=%h addr=%h exp=0/0/0/100", instValid, memREn, instPc, memAddr);
        end
        rstN = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misaligned();
        test_pause();
        test_redir_idle();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
